// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, data width and bit-period helpers for fifo_uart_tx; PARITY exists only with UART_PARITY_EN
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  function automatic int bit_cnt_max(int clk_freq, int baud);
    return clk_freq / baud;
  endfunction
  function automatic int bit_cnt_w(int clk_freq, int baud);
    return $clog2(bit_cnt_max(clk_freq, baud)) < 1 ? 1 : $clog2(bit_cnt_max(clk_freq, baud));
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter, cleared on state entry, pulses bit_done on its last count
module uart_bit_timer #(
  parameter int MAX = 434,
  parameter int W = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_done
);
  localparam logic [W-1:0] LAST = W'(MAX - 1);
  logic [W-1:0] cnt;
  assign bit_done = cnt == LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || bit_done) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains the FIFO and sends each byte as a UART frame, LSB first; UART_PARITY_EN inserts an even-parity bit
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdempty,
  input  logic [DATA_W-1:0] q,
  output logic              rdreq,
  output logic              tx,
  output logic              busy
);
  localparam int BCM = bit_cnt_max(CLK_FREQ, BAUD);
  localparam int CW = bit_cnt_w(CLK_FREQ, BAUD);
  state_t state, state_n;
  logic [2:0] idx, idx_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic tx_n, bit_done;
  uart_bit_timer #(.MAX(BCM), .W(CW)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state_n != state),
    .bit_done(bit_done)
  );
  // sh rotates rather than shifts, so it holds the original byte again once DATA ends
  always_comb begin
    state_n = state;
    idx_n = idx;
    sh_n = sh;
    case (state)
      IDLE: state_n = rdempty ? IDLE : REQ;
      REQ: state_n = LOAD;
      LOAD: begin
        state_n = START;
        sh_n = q;
      end
      START: begin
        state_n = bit_done ? DATA : START;
        idx_n = '0;
      end
      DATA: if (bit_done) begin
        sh_n = {sh[0], sh[DATA_W-1:1]};
        idx_n = idx + 3'd1;
`ifdef UART_PARITY_EN
        state_n = (idx == 3'd7) ? PARITY : DATA;
`else
        state_n = (idx == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_PARITY_EN
      PARITY: state_n = bit_done ? STOP : PARITY;
`endif
      STOP: state_n = bit_done ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
`ifdef UART_PARITY_EN
  assign tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : (state_n == PARITY) ? ^sh_n : 1'b1;
`else
  assign tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
      rdreq <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      sh <= sh_n;
      tx <= tx_n;
      rdreq <= state_n == REQ;
      busy <= state_n != IDLE;
    end
endmodule
